pipe_gap_sched: RTL and testbench
=================================

PIPE_GAP_SCHED -- requirements
Module: pipe_gap_sched

Interface
REQ-001 Parameter NUM_REQ, default 3: number of pipe-slot requesters.
REQ-002 Parameter STEPS, default 8: LFSR advance cycles per request.
REQ-003 Parameter GAP_MIN, default 8'd40: lowest legal gap_y.
REQ-004 Parameter GAP_MAX, default 8'd200: highest legal gap_y.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flap  in  1  synchronous bird-control level; each rising edge decrements the seed counter.
REQ-008 start  in  1  one-cycle pulse; requests a reseed of the LFSR.
REQ-009 req  in  NUM_REQ  per-slot gap request, level, held until matching ack.
REQ-010 rand_num  in  8  current LFSR state.
REQ-011 lfsr_step  out  1  LFSR advance enable.
REQ-012 lfsr_load  out  1  one-cycle seed-load strobe.
REQ-013 lfsr_seed  out  8  seed value, valid when lfsr_load=1.
REQ-014 ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-015 gap_y  out  8  clamped gap position, valid while ack!=0, held otherwise.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, STEP, SETTLE, ACK.
REQ-018 Seed counter: 8 bits, reset 8'hFF, decrements by 1 on each detected flap rising edge (flap sampled into a 1-bit history register); value 8'h01 decrements to 8'hFF, never 8'h00.
REQ-019 flap edges SHALL be counted in every FSM state, including busy states.
REQ-020 start SHALL set a pending-reseed flag in any state; flag clears when LOAD is entered.
REQ-021 IDLE: pending reseed has priority over req -> LOAD; else any req bit high -> STEP; else stay.
REQ-022 LOAD (1 cycle): lfsr_load=1, lfsr_seed=seed counter; -> IDLE.
REQ-023 IDLE->STEP: grant chosen round-robin, search starting at index (last_grant+1) mod NUM_REQ; grant index registered; step counter loaded with STEPS.
REQ-024 STEP: lfsr_step=1 each cycle; counter decrements; after STEPS cycles -> SETTLE.
REQ-025 SETTLE (1 cycle): lfsr_step=0; at exit edge gap_y <= clamp(rand_num); -> ACK.
REQ-026 clamp: rand_num<GAP_MIN -> GAP_MIN; rand_num>GAP_MAX -> GAP_MAX; else rand_num unchanged.
REQ-027 ACK (1 cycle): ack[grant]=1, all other ack bits 0; last_grant <= grant; -> IDLE.
REQ-028 Latency: req first sampled high in IDLE at edge k -> ack high in cycle k+STEPS+2.
REQ-029 req deasserted by its owner mid-transaction SHALL NOT abort it; ack still issued.
REQ-030 A requester holding req after its ack SHALL be treated as a new request, subject to round-robin.
REQ-031 lfsr_step and lfsr_load SHALL never be high in the same cycle.

Reset
REQ-032 rst=1 at a clock edge -> state IDLE, seed counter 8'hFF, pending flag 0, last_grant NUM_REQ-1 (first grant search starts at 0), gap_y 8'd0, ack 0, lfsr_step 0, lfsr_load 0, lfsr_seed 8'd0, busy 0, flap history 0.
REQ-033 rst mid-transaction SHALL abandon it with no ack; rst dominates all other inputs.

Verification
REQ-034 Reset, then req=3'b001 held, rand_num=8'd100 during SETTLE -> lfsr_step high exactly 8 cycles, ack=3'b001 at cycle k+10, gap_y=100.
REQ-035 req=3'b111 held continuously -> acks in order 001, 010, 100, 001; each transaction is 11 cycles (10 to ack plus return to IDLE).
REQ-036 rand_num=8'd10 at SETTLE -> gap_y=40; rand_num=8'd250 -> gap_y=200; rand_num=8'd40 and 8'd200 pass unchanged.
REQ-037 Three flap rising edges after reset, then start -> LOAD cycle with lfsr_load=1, lfsr_seed=8'hFC; flap held high for 5 cycles counts once.
REQ-038 Seed counter driven to 8'h01, one more flap edge -> 8'hFF; start asserted during STEP -> LOAD occurs immediately after the ack, ahead of any pending req.
REQ-039 rst asserted in STEP -> next cycle busy=0, lfsr_step=0, no ack for the aborted request; seed counter 8'hFF.

Source files
------------

// File: rtl/pipe_gap_sched.sv
// Pipe gap scheduler: serves round-robin gap requests by stepping an external
// LFSR a fixed number of cycles, clamps the result into the legal gap window,
// and reseeds the LFSR from a flap-driven counter when a start is requested.
module pipe_gap_sched #(
  parameter int          NUM_REQ = 3,
  parameter int          STEPS   = 8,
  parameter logic [7:0]  GAP_MIN = 8'd40,
  parameter logic [7:0]  GAP_MAX = 8'd200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flap,
  input  logic               start,
  input  logic [NUM_REQ-1:0] req,
  input  logic [7:0]         rand_num,
  output logic               lfsr_step,
  output logic               lfsr_load,
  output logic [7:0]         lfsr_seed,
  output logic [NUM_REQ-1:0] ack,
  output logic [7:0]         gap_y,
  output logic               busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(STEPS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, ACK} state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    seed_cnt;
  logic          flap_q;
  logic          pending;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] rr_pick;
  logic [GW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] step_cnt;

  function automatic logic [7:0] clamp_gap(input logic [7:0] v);
    if (v < GAP_MIN) return GAP_MIN;
    if (v > GAP_MAX) return GAP_MAX;
    return v;
  endfunction

  // Round-robin search beginning just after the most recently served slot.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Next-state logic; a pending reseed always wins over a waiting request.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pending)       state_nx = LOAD;
        else if (rr_found) state_nx = STEP;
      end
      LOAD:    state_nx = IDLE;
      STEP:    if (step_cnt == SW'(1)) state_nx = SETTLE;
      SETTLE:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; step and load are exclusive.
  always_comb begin
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    lfsr_seed = 8'd0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        lfsr_load = 1'b1;
        lfsr_seed = seed_cnt;
      end
      STEP:    lfsr_step = 1'b1;
      ACK:     ack[grant] = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Seed counter counts flap rising edges in every state and skips zero on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      flap_q   <= 1'b0;
      seed_cnt <= 8'hFF;
    end else begin
      flap_q <= flap;
      if (flap && !flap_q)
        seed_cnt <= (seed_cnt == 8'h01) ? 8'hFF : seed_cnt - 8'd1;
    end
  end

  // Reseed request is remembered until the FSM actually enters LOAD.
  always_ff @(posedge clk) begin
    if (rst)                          pending <= 1'b0;
    else if (start)                   pending <= 1'b1;
    else if (state == IDLE && pending) pending <= 1'b0;
  end

  // Transaction bookkeeping: grant capture, step countdown, gap capture, fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      step_cnt   <= '0;
      gap_y      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!pending && rr_found) begin
            grant    <= rr_pick;
            step_cnt <= SW'(STEPS);
          end
        end
        STEP:    step_cnt <= step_cnt - SW'(1);
        SETTLE:  gap_y <= clamp_gap(rand_num);
        ACK:     last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_gap_sched.sv
// Scoreboard bench for pipe_gap_sched: expected acks/gaps are queued when a
// request is driven and compared when the DUT raises ack.
module tb_pipe_gap_sched;

  localparam int NUM_REQ = 3;
  localparam int STEPS   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flap = 1'b0;
  logic       start = 1'b0;
  logic [2:0] req = 3'b000;
  logic [7:0] rand_num = 8'd150;
  logic       lfsr_step;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic [2:0] ack;
  logic [7:0] gap_y;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] ack;
    logic [7:0] gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_seed;

  pipe_gap_sched #(
    .NUM_REQ(NUM_REQ),
    .STEPS  (STEPS),
    .GAP_MIN(8'd40),
    .GAP_MAX(8'd200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flap     (flap),
    .start    (start),
    .req      (req),
    .rand_num (rand_num),
    .lfsr_step(lfsr_step),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed),
    .ack      (ack),
    .gap_y    (gap_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_clamp(input logic [7:0] v);
    if (v < 8'd40)  return 8'd40;
    if (v > 8'd200) return 8'd200;
    return v;
  endfunction

  function automatic logic [7:0] seed_dec(input logic [7:0] s);
    return (s == 8'h01) ? 8'hFF : s - 8'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flap = 1'b0; start = 1'b0; req = 3'b000; rand_num = 8'd150;
    repeat (2) tick();
    rst = 1'b0;
    exp_seed = 8'hFF;
  endtask

  // Called in an IDLE cycle with req already driven; walks forward until ack,
  // presenting settle_val on rand_num only in the cycle the value is sampled.
  task automatic run_to_ack(input logic [7:0] settle_val, input int flap_at, input int start_at,
                            output int ack_at, output int steps_seen, output int overlap);
    ack_at = -1; steps_seen = 0; overlap = 0;
    for (int c = 1; c <= 20 && ack_at < 0; c++) begin
      tick();
      rand_num = (c == STEPS + 1) ? settle_val : 8'd150;
      flap     = (c == flap_at);
      start    = (c == start_at);
      if (lfsr_step) steps_seen++;
      if (lfsr_step && lfsr_load) overlap++;
      if (ack != 3'b000) ack_at = c;
    end
    flap = 1'b0; start = 1'b0; rand_num = 8'd150;
  endtask

  task automatic wait_load(output int found);
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      tick();
      if (lfsr_load) found = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ack !== 3'b000)     begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (lfsr_step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %b expected 0", lfsr_step); end
    checks++; if (lfsr_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load: got %b expected 0", lfsr_load); end
    checks++; if (lfsr_seed !== 8'd0) begin errors++; $display("[TB] FAIL reset_seed: got %0d expected 0", lfsr_seed); end
    checks++; if (gap_y !== 8'd0)     begin errors++; $display("[TB] FAIL reset_gap: got %0d expected 0", gap_y); end
  endtask

  task automatic test_basic();
    exp_t e;
    int ack_at, steps, ov;
    exp_q.push_back('{ack: 3'b001, gap: exp_clamp(8'd100)});
    req = 3'b001;
    run_to_ack(8'd100, -1, -1, ack_at, steps, ov);
    req = 3'b000;
    checks++; if (ack_at !== 10) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 10", ack_at); end
    checks++; if (steps !== STEPS) begin errors++; $display("[TB] FAIL basic_steps: got %0d expected %0d", steps, STEPS); end
    checks++; if (ov !== 0) begin errors++; $display("[TB] FAIL basic_overlap: got %0d expected 0", ov); end
    e = exp_q.pop_front();
    checks++; if (ack !== e.ack) begin errors++; $display("[TB] FAIL basic_ack: got %b expected %b", ack, e.ack); end
    checks++; if (gap_y !== e.gap) begin errors++; $display("[TB] FAIL basic_gap: got %0d expected %0d", gap_y, e.gap); end
    tick();
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL basic_ack_pulse: got %b expected 000", ack); end
    checks++; if (gap_y !== e.gap) begin errors++; $display("[TB] FAIL basic_gap_hold: got %0d expected %0d", gap_y, e.gap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] vals [4] = '{8'd10, 8'd250, 8'd40, 8'd200};
    exp_t e;
    int ack_at, steps, ov;
    logic [2:0] ea;
    do_reset();
    req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      ea = 3'b001 << (t % 3);
      exp_q.push_back('{ack: ea, gap: exp_clamp(vals[t])});
      run_to_ack(vals[t], -1, -1, ack_at, steps, ov);
      checks++; if (ack_at !== 10) begin errors++; $display("[TB] FAIL rr_latency[%0d]: got %0d expected 10", t, ack_at); end
      checks++; if (steps !== STEPS) begin errors++; $display("[TB] FAIL rr_steps[%0d]: got %0d expected %0d", t, steps, STEPS); end
      e = exp_q.pop_front();
      checks++; if (ack !== e.ack) begin errors++; $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", t, ack, e.ack); end
      checks++; if (gap_y !== e.gap) begin errors++; $display("[TB] FAIL rr_gap[%0d]: got %0d expected %0d", t, gap_y, e.gap); end
      if (t == 3) req = 3'b000;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle[%0d]: got %b expected 0", t, busy); end
    end
  endtask

  task automatic test_flap_seed();
    int found;
    do_reset();
    flap = 1'b1; repeat (5) tick(); flap = 1'b0; tick();
    exp_seed = seed_dec(exp_seed);
    repeat (2) begin
      flap = 1'b1; tick(); flap = 1'b0; tick();
      exp_seed = seed_dec(exp_seed);
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_load(found);
    checks++; if (found !== 1) begin errors++; $display("[TB] FAIL flap_load_seen: got %0d expected 1", found); end
    checks++; if (lfsr_seed !== 8'hFC) begin errors++; $display("[TB] FAIL flap_seed: got %h expected fc", lfsr_seed); end
    checks++; if (lfsr_step !== 1'b0) begin errors++; $display("[TB] FAIL flap_step_excl: got %b expected 0", lfsr_step); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flap_load_busy: got %b expected 1", busy); end
    tick();
    checks++; if (lfsr_load !== 1'b0) begin errors++; $display("[TB] FAIL flap_load_pulse: got %b expected 0", lfsr_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flap_back_idle: got %b expected 0", busy); end
  endtask

  task automatic test_wrap_priority();
    exp_t e;
    int found, ack_at, steps, ov;
    do_reset();
    for (int i = 0; i < 254; i++) begin
      flap = 1'b1; tick(); flap = 1'b0; tick();
      exp_seed = seed_dec(exp_seed);
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_load(found);
    checks++; if (found !== 1) begin errors++; $display("[TB] FAIL wrap_load1_seen: got %0d expected 1", found); end
    checks++; if (lfsr_seed !== exp_seed) begin errors++; $display("[TB] FAIL wrap_seed01: got %h expected %h", lfsr_seed, exp_seed); end
    tick();
    req = 3'b011;
    exp_q.push_back('{ack: 3'b001, gap: exp_clamp(8'd77)});
    run_to_ack(8'd77, 3, 4, ack_at, steps, ov);
    exp_seed = seed_dec(exp_seed);
    checks++; if (ack_at !== 10) begin errors++; $display("[TB] FAIL wrap_latency: got %0d expected 10", ack_at); end
    e = exp_q.pop_front();
    checks++; if (ack !== e.ack) begin errors++; $display("[TB] FAIL wrap_ack: got %b expected %b", ack, e.ack); end
    checks++; if (gap_y !== e.gap) begin errors++; $display("[TB] FAIL wrap_gap: got %0d expected %0d", gap_y, e.gap); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle: got %b expected 0", busy); end
    tick();
    checks++; if (lfsr_load !== 1'b1) begin errors++; $display("[TB] FAIL wrap_load_first: got %b expected 1", lfsr_load); end
    checks++; if (lfsr_seed !== exp_seed) begin errors++; $display("[TB] FAIL wrap_seedff: got %h expected %h", lfsr_seed, exp_seed); end
    checks++; if (lfsr_step !== 1'b0) begin errors++; $display("[TB] FAIL wrap_step_excl: got %b expected 0", lfsr_step); end
    tick();
    exp_q.push_back('{ack: 3'b010, gap: exp_clamp(8'd180)});
    run_to_ack(8'd180, -1, -1, ack_at, steps, ov);
    req = 3'b000;
    checks++; if (ack_at !== 10) begin errors++; $display("[TB] FAIL wrap_next_latency: got %0d expected 10", ack_at); end
    e = exp_q.pop_front();
    checks++; if (ack !== e.ack) begin errors++; $display("[TB] FAIL wrap_next_ack: got %b expected %b", ack, e.ack); end
    checks++; if (gap_y !== e.gap) begin errors++; $display("[TB] FAIL wrap_next_gap: got %0d expected %0d", gap_y, e.gap); end
    tick();
  endtask

  task automatic test_reset_mid();
    int found, acks;
    do_reset();
    repeat (2) begin
      flap = 1'b1; tick(); flap = 1'b0; tick();
    end
    req = 3'b100;
    repeat (4) tick();
    checks++; if (lfsr_step !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_step: got %b expected 1", lfsr_step); end
    rst = 1'b1; req = 3'b000;
    tick();
    rst = 1'b0;
    exp_seed = 8'hFF;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (lfsr_step !== 1'b0) begin errors++; $display("[TB] FAIL mid_step: got %b expected 0", lfsr_step); end
    acks = 0;
    for (int c = 0; c < 15; c++) begin
      if (ack != 3'b000) acks++;
      tick();
    end
    checks++; if (acks !== 0) begin errors++; $display("[TB] FAIL mid_no_ack: got %0d expected 0", acks); end
    start = 1'b1; tick(); start = 1'b0;
    wait_load(found);
    checks++; if (found !== 1) begin errors++; $display("[TB] FAIL mid_load_seen: got %0d expected 1", found); end
    checks++; if (lfsr_seed !== exp_seed) begin errors++; $display("[TB] FAIL mid_seed: got %h expected %h", lfsr_seed, exp_seed); end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_flap_seed();
    test_wrap_priority();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
